// File: rtl/phy_tx_pkg.sv
// Shared definitions for the two-lane PHY transmit link controller:
// link state encoding and the default COM/IDLE symbols.
package phy_tx_pkg;

  // 2-bit link state, encoded as reported on link_state
  typedef enum logic [1:0] {
    LS_RESET  = 2'd0,
    LS_INIT   = 2'd1,
    LS_IDLE   = 2'd2,
    LS_ACTIVE = 2'd3
  } link_state_t;

  localparam logic [7:0] COM_SYM_DEFAULT = 8'hBC;
  localparam logic [7:0] IDL_SYM_DEFAULT = 8'h7C;

  // The link counts as up only once it has reached ACTIVE
  function automatic logic is_link_up(input link_state_t s);
    return (s == LS_ACTIVE);
  endfunction

endpackage

// File: rtl/phy_credit_cnt.sv
// Per-lane transmit credit counter. Starts full, counts down on each
// accepted byte and up on each returned credit. Saturates at CREDIT_MAX
// and never goes below zero. 'restore' refills it when the link drops.
module phy_credit_cnt #(
  parameter int CREDIT_MAX = 8,
  parameter int CW         = 4
) (
  input  logic          clk_2f,
  input  logic          reset,
  input  logic          restore,
  input  logic          take,
  input  logic          give,
  output logic [CW-1:0] count,
  output logic          nonzero
);

  localparam logic [CW-1:0] MAX_VAL = CW'(CREDIT_MAX);

  logic [CW-1:0] r_count;

  // Credit update: take and give together cancel out
  always_ff @(posedge clk_2f) begin
    if (reset || restore) begin
      r_count <= MAX_VAL;
    end else if (take && !give && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end else if (give && !take && (r_count != MAX_VAL)) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign count   = r_count;
  assign nonzero = (r_count != '0);

endmodule

// File: rtl/phy_tx_link_ctrl.sv
// Link sequencer and credit-based flow controller in front of the
// two-lane PHY transmit path. Brings the link up through INIT (COM on
// both lanes) and IDLE, then passes source bytes in ACTIVE under per-lane
// credits. Optional build macro PHY_LANE_LOCK_EN makes both lanes accept
// and emit in lockstep; without it the lanes are independent.
module phy_tx_link_ctrl
  import phy_tx_pkg::*;
#(
  parameter int         INIT_CYCLES = 16,
  parameter int         CREDIT_MAX  = 8,
  parameter int         CW          = 4,
  parameter logic [7:0] COM_SYM     = COM_SYM_DEFAULT,
  parameter logic [7:0] IDL_SYM     = IDL_SYM_DEFAULT
) (
  input  logic       clk_2f,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] src_data0,
  input  logic       src_valid0,
  output logic       src_ready0,
  input  logic [7:0] src_data1,
  input  logic       src_valid1,
  output logic       src_ready1,
  input  logic       credit_ret0,
  input  logic       credit_ret1,
  output logic [7:0] data_out0,
  output logic       valid_out0,
  output logic [7:0] data_out1,
  output logic       valid_out1,
  output logic [1:0] link_state,
  output logic       link_up
);

  localparam int            ICW       = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [ICW-1:0] INIT_LAST = ICW'(INIT_CYCLES - 1);
  localparam logic [CW-1:0]  CRED_FULL = CW'(CREDIT_MAX);

  link_state_t    r_state;
  link_state_t    w_state_next;
  logic [ICW-1:0] r_init_cnt;
  logic           w_active;
  logic           w_restore;

  logic [7:0]     w_src_data   [2];
  logic [1:0]     w_src_valid;
  logic [1:0]     w_credit_ret;
  logic [1:0]     w_ready;
  logic [1:0]     w_take;
  logic [1:0]     w_give;
  logic [1:0]     w_nonzero;
  logic [CW-1:0]  w_credit     [2];
  logic [7:0]     r_data_out   [2];
  logic [1:0]     r_valid_out;

  assign w_src_data[0]   = src_data0;
  assign w_src_data[1]   = src_data1;
  assign w_src_valid     = {src_valid1, src_valid0};
  assign w_credit_ret    = {credit_ret1, credit_ret0};

  assign w_active  = (r_state == LS_ACTIVE);
  // Going down (or staying down) refills every lane's credits
  assign w_restore = (w_state_next == LS_RESET);

  // Link state register
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      r_state <= LS_RESET;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; dropping enable takes any live state back to RESET
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      LS_RESET: begin
        if (enable) w_state_next = LS_INIT;
      end
      LS_INIT: begin
        if (!enable)                        w_state_next = LS_RESET;
        else if (r_init_cnt == INIT_LAST)   w_state_next = LS_IDLE;
      end
      LS_IDLE: begin
        w_state_next = enable ? LS_ACTIVE : LS_RESET;
      end
      LS_ACTIVE: begin
        if (!enable) w_state_next = LS_RESET;
      end
      default: w_state_next = LS_RESET;
    endcase
  end

  // INIT dwell counter: zero outside INIT so each entry starts from 0
  always_ff @(posedge clk_2f) begin
    if (reset || (r_state != LS_INIT)) begin
      r_init_cnt <= '0;
    end else begin
      r_init_cnt <= r_init_cnt + ICW'(1);
    end
  end

`ifdef PHY_LANE_LOCK_EN
  logic w_lock_go;
  // Lockstep: accept only when both lanes have credit and both have data
  assign w_lock_go = w_active && enable && (&w_nonzero) && (&w_src_valid);
  assign w_ready   = {2{w_lock_go}};
`else
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      assign w_ready[gi] = w_active && enable && w_nonzero[gi];
    end
  endgenerate
`endif

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      assign w_take[gi] = w_src_valid[gi] && w_ready[gi];
      // Returns are ignored while the link is held in RESET; a return at
      // full credit is dropped here before it reaches the counter
      assign w_give[gi] = w_credit_ret[gi] && (r_state != LS_RESET) &&
                          (w_credit[gi] != CRED_FULL);

      phy_credit_cnt #(
        .CREDIT_MAX (CREDIT_MAX),
        .CW         (CW)
      ) u_credit (
        .clk_2f  (clk_2f),
        .reset   (reset),
        .restore (w_restore),
        .take    (w_take[gi]),
        .give    (w_give[gi]),
        .count   (w_credit[gi]),
        .nonzero (w_nonzero[gi])
      );

      // Lane output register: driven from the state being entered so the
      // symbols line up with the link_state reported in the same cycle
      always_ff @(posedge clk_2f) begin
        if (reset) begin
          r_data_out[gi]  <= 8'h00;
          r_valid_out[gi] <= 1'b0;
        end else begin
          case (w_state_next)
            LS_INIT: begin
              r_data_out[gi]  <= COM_SYM;
              r_valid_out[gi] <= 1'b1;
            end
            LS_IDLE: begin
              r_data_out[gi]  <= IDL_SYM;
              r_valid_out[gi] <= 1'b0;
            end
            LS_ACTIVE: begin
              if (w_take[gi]) begin
                r_data_out[gi]  <= w_src_data[gi];
                r_valid_out[gi] <= 1'b1;
              end else begin
                r_data_out[gi]  <= IDL_SYM;
                r_valid_out[gi] <= 1'b0;
              end
            end
            default: begin
              r_data_out[gi]  <= 8'h00;
              r_valid_out[gi] <= 1'b0;
            end
          endcase
        end
      end
    end
  endgenerate

  assign src_ready0 = w_ready[0];
  assign src_ready1 = w_ready[1];
  assign data_out0  = r_data_out[0];
  assign valid_out0 = r_valid_out[0];
  assign data_out1  = r_data_out[1];
  assign valid_out1 = r_valid_out[1];
  assign link_state = r_state;
  assign link_up    = is_link_up(r_state);

endmodule

// File: tb/tb_phy_tx_link_ctrl.sv
// Directed bench for phy_tx_link_ctrl: link bring-up, lane-0 credit
// streaming from a vector table, credit return corners, link drop and
// restart. With PHY_LANE_LOCK_EN defined, the lockstep acceptance case
// replaces the independent-lane sequences.
module tb_phy_tx_link_ctrl;

  logic       clk_2f = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] src_data0, src_data1;
  logic       src_valid0, src_valid1;
  logic       src_ready0, src_ready1;
  logic       credit_ret0, credit_ret1;
  logic [7:0] data_out0, data_out1;
  logic       valid_out0, valid_out1;
  logic [1:0] link_state;
  logic       link_up;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       v0;
    logic [7:0] d0;
    logic [7:0] e_d0;
    logic       e_v0;
    logic [3:0] e_cr0;
    logic       e_rdy0;
  } vec_t;

  vec_t vecs [10];

  always #5 clk_2f = ~clk_2f;

  phy_tx_link_ctrl dut (
    .clk_2f      (clk_2f),
    .reset       (reset),
    .enable      (enable),
    .src_data0   (src_data0),
    .src_valid0  (src_valid0),
    .src_ready0  (src_ready0),
    .src_data1   (src_data1),
    .src_valid1  (src_valid1),
    .src_ready1  (src_ready1),
    .credit_ret0 (credit_ret0),
    .credit_ret1 (credit_ret1),
    .data_out0   (data_out0),
    .valid_out0  (valid_out0),
    .data_out1   (data_out1),
    .valid_out1  (valid_out1),
    .link_state  (link_state),
    .link_up     (link_up)
  );

  task automatic tick();
    @(posedge clk_2f);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_lanes(input string tag, input logic [7:0] d0, input logic v0,
                           input logic [7:0] d1, input logic v1);
    chk({tag, ".data_out0"},  {24'd0, data_out0}, {24'd0, d0});
    chk({tag, ".valid_out0"}, {31'd0, valid_out0}, {31'd0, v0});
    chk({tag, ".data_out1"},  {24'd0, data_out1}, {24'd0, d1});
    chk({tag, ".valid_out1"}, {31'd0, valid_out1}, {31'd0, v1});
  endtask

  task automatic chk_credits(input string tag, input int c0, input int c1);
    chk({tag, ".credit0"}, {28'd0, dut.w_credit[0]}, c0);
    chk({tag, ".credit1"}, {28'd0, dut.w_credit[1]}, c1);
  endtask

  // Raise enable from RESET and walk INIT (16 cycles), IDLE (1), ACTIVE
  task automatic bring_up(input string tag);
    enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk({tag, ".init_state"}, {30'd0, link_state}, 32'd1);
      chk_lanes({tag, ".init"}, 8'hBC, 1'b1, 8'hBC, 1'b1);
    end
    $display("%s: INIT phase of 16 cycles observed", tag);
    tick();
    chk({tag, ".idle_state"}, {30'd0, link_state}, 32'd2);
    chk({tag, ".idle_link_up"}, {31'd0, link_up}, 32'd0);
    chk_lanes({tag, ".idle"}, 8'h7C, 1'b0, 8'h7C, 1'b0);
    tick();
    chk({tag, ".active_state"}, {30'd0, link_state}, 32'd3);
    chk({tag, ".active_link_up"}, {31'd0, link_up}, 32'd1);
    chk_lanes({tag, ".active0"}, 8'h7C, 1'b0, 8'h7C, 1'b0);
    chk_credits({tag, ".active"}, 8, 8);
    $display("%s: link ACTIVE, state=%0d link_up=%0b", tag, link_state, link_up);
  endtask

  initial begin
    // Lane-0 streaming: 0x01..0x08 consume all 8 credits, then 0x09 waits
    vecs[0] = '{1'b1, 8'h01, 8'h01, 1'b1, 4'd7, 1'b1};
    vecs[1] = '{1'b1, 8'h02, 8'h02, 1'b1, 4'd6, 1'b1};
    vecs[2] = '{1'b1, 8'h03, 8'h03, 1'b1, 4'd5, 1'b1};
    vecs[3] = '{1'b1, 8'h04, 8'h04, 1'b1, 4'd4, 1'b1};
    vecs[4] = '{1'b1, 8'h05, 8'h05, 1'b1, 4'd3, 1'b1};
    vecs[5] = '{1'b1, 8'h06, 8'h06, 1'b1, 4'd2, 1'b1};
    vecs[6] = '{1'b1, 8'h07, 8'h07, 1'b1, 4'd1, 1'b1};
    vecs[7] = '{1'b1, 8'h08, 8'h08, 1'b1, 4'd0, 1'b0};
    vecs[8] = '{1'b1, 8'h09, 8'h7C, 1'b0, 4'd0, 1'b0};
    vecs[9] = '{1'b1, 8'h09, 8'h7C, 1'b0, 4'd0, 1'b0};

    reset       = 1'b1;
    enable      = 1'b0;
    src_data0   = 8'h00;
    src_data1   = 8'h00;
    src_valid0  = 1'b0;
    src_valid1  = 1'b0;
    credit_ret0 = 1'b0;
    credit_ret1 = 1'b0;
    tick();
    tick();

    chk("rst.link_state", {30'd0, link_state}, 32'd0);
    chk("rst.link_up", {31'd0, link_up}, 32'd0);
    chk("rst.src_ready0", {31'd0, src_ready0}, 32'd0);
    chk("rst.src_ready1", {31'd0, src_ready1}, 32'd0);
    chk_lanes("rst", 8'h00, 1'b0, 8'h00, 1'b0);
    chk_credits("rst", 8, 8);

    reset = 1'b0;
    tick();
    chk("hold_reset.link_state", {30'd0, link_state}, 32'd0);

    bring_up("up1");

`ifndef PHY_LANE_LOCK_EN
    for (int i = 0; i < 10; i++) begin
      src_valid0 = vecs[i].v0;
      src_data0  = vecs[i].d0;
      tick();
      $display("vec %0d: in d0=%02h v0=%0b -> out0=%02h/%0b credit0=%0d ready0=%0b",
               i, vecs[i].d0, vecs[i].v0, data_out0, valid_out0, dut.w_credit[0], src_ready0);
      chk("stream.data_out0", {24'd0, data_out0}, {24'd0, vecs[i].e_d0});
      chk("stream.valid_out0", {31'd0, valid_out0}, {31'd0, vecs[i].e_v0});
      chk("stream.credit0", {28'd0, dut.w_credit[0]}, {28'd0, vecs[i].e_cr0});
      chk("stream.src_ready0", {31'd0, src_ready0}, {31'd0, vecs[i].e_rdy0});
      chk("stream.data_out1", {24'd0, data_out1}, 32'h7C);
      chk("stream.valid_out1", {31'd0, valid_out1}, 32'd0);
      chk("stream.src_ready1", {31'd0, src_ready1}, 32'd1);
    end

    // One return at zero credit: ready comes back, held 0x09 goes out
    credit_ret0 = 1'b1;
    tick();
    credit_ret0 = 1'b0;
    $display("ret_at_zero: credit0=%0d ready0=%0b", dut.w_credit[0], src_ready0);
    chk("ret0.credit0", {28'd0, dut.w_credit[0]}, 32'd1);
    chk("ret0.src_ready0", {31'd0, src_ready0}, 32'd1);
    chk("ret0.valid_out0", {31'd0, valid_out0}, 32'd0);
    tick();
    $display("send_09: out0=%02h/%0b credit0=%0d", data_out0, valid_out0, dut.w_credit[0]);
    chk("send09.data_out0", {24'd0, data_out0}, 32'h09);
    chk("send09.valid_out0", {31'd0, valid_out0}, 32'd1);
    chk("send09.credit0", {28'd0, dut.w_credit[0]}, 32'd0);
    chk("send09.src_ready0", {31'd0, src_ready0}, 32'd0);
    src_valid0 = 1'b0;

    // Build credit up to 3, then transfer and return in the same cycle
    credit_ret0 = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("build3.credit0", {28'd0, dut.w_credit[0]}, 32'd3);
    src_valid0 = 1'b1;
    src_data0  = 8'h55;
    tick();
    src_valid0 = 1'b0;
    $display("coincident: out0=%02h/%0b credit0=%0d", data_out0, valid_out0, dut.w_credit[0]);
    chk("coinc.data_out0", {24'd0, data_out0}, 32'h55);
    chk("coinc.valid_out0", {31'd0, valid_out0}, 32'd1);
    chk("coinc.credit0", {28'd0, dut.w_credit[0]}, 32'd3);
    for (int i = 0; i < 5; i++) tick();
    chk("fill.credit0", {28'd0, dut.w_credit[0]}, 32'd8);
    tick();
    credit_ret0 = 1'b0;
    $display("saturate: credit0=%0d", dut.w_credit[0]);
    chk("sat.credit0", {28'd0, dut.w_credit[0]}, 32'd8);
    chk("sat.data_out0", {24'd0, data_out0}, 32'h7C);

    // Lane 1 on its own
    src_valid1 = 1'b1;
    src_data1  = 8'hA5;
    tick();
    src_valid1 = 1'b0;
    $display("lane1: out1=%02h/%0b credit1=%0d", data_out1, valid_out1, dut.w_credit[1]);
    chk_lanes("lane1", 8'h7C, 1'b0, 8'hA5, 1'b1);
    chk_credits("lane1", 8, 7);
    tick();
    chk_lanes("lane1_after", 8'h7C, 1'b0, 8'h7C, 1'b0);
`else
    // Lockstep: one lane valid alone does not open either lane
    src_valid0 = 1'b1;
    src_data0  = 8'h11;
    src_valid1 = 1'b0;
    #1;
    chk("lock_half.src_ready0", {31'd0, src_ready0}, 32'd0);
    chk("lock_half.src_ready1", {31'd0, src_ready1}, 32'd0);
    tick();
    $display("lock_half: out0=%02h/%0b out1=%02h/%0b", data_out0, valid_out0, data_out1, valid_out1);
    chk_lanes("lock_half", 8'h7C, 1'b0, 8'h7C, 1'b0);
    chk_credits("lock_half", 8, 8);
    src_valid1 = 1'b1;
    src_data1  = 8'h22;
    #1;
    chk("lock_both.src_ready0", {31'd0, src_ready0}, 32'd1);
    chk("lock_both.src_ready1", {31'd0, src_ready1}, 32'd1);
    tick();
    src_valid0 = 1'b0;
    src_valid1 = 1'b0;
    $display("lock_both: out0=%02h/%0b out1=%02h/%0b", data_out0, valid_out0, data_out1, valid_out1);
    chk_lanes("lock_both", 8'h11, 1'b1, 8'h22, 1'b1);
    chk_credits("lock_both", 7, 7);
`endif

    // Drop enable with data pending: nothing is accepted, link resets
    src_valid0 = 1'b1;
    src_data0  = 8'h66;
    src_valid1 = 1'b1;
    src_data1  = 8'h77;
    enable     = 1'b0;
    #1;
    chk("drop.src_ready0", {31'd0, src_ready0}, 32'd0);
    chk("drop.src_ready1", {31'd0, src_ready1}, 32'd0);
    tick();
    $display("link_drop: state=%0d out0=%02h/%0b out1=%02h/%0b", link_state,
             data_out0, valid_out0, data_out1, valid_out1);
    chk("drop.link_state", {30'd0, link_state}, 32'd0);
    chk("drop.link_up", {31'd0, link_up}, 32'd0);
    chk_lanes("drop", 8'h00, 1'b0, 8'h00, 1'b0);
    chk_credits("drop", 8, 8);
    src_valid0 = 1'b0;
    src_valid1 = 1'b0;
    tick();
    chk("drop_hold.link_state", {30'd0, link_state}, 32'd0);

    bring_up("up2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/phy_tx_link_ctrl.md
Name: phy_tx_link_ctrl

Overview:
- Link sequencer and flow controller in front of the two-lane PHY transmit path.
- Brings the link up by forcing COM symbols on both lanes, then IDLE, then ACTIVE.
- In ACTIVE it passes source bytes to the lane inputs (data/valid per lane) under per-lane credit control.
- Sits between the upstream byte sources and the transmit datapath; runs entirely on clk_2f.

Parameters:
- INIT_CYCLES, 16, cycles spent in INIT driving COM on both lanes (>=1).
- CREDIT_MAX, 8, credits per lane after reset / link restart (1..15).
- CW, 4, credit counter width; must hold CREDIT_MAX.
- COM_SYM, 8'hBC, symbol driven during INIT.
- IDL_SYM, 8'h7C, symbol driven whenever a lane carries no valid data.

Ports:
- clk_2f  in  1  sole clock
- reset  in  1  synchronous, active-high
- enable  in  1  link enable; low forces link down
- src_data0  in  8  lane-0 source byte
- src_valid0  in  1  lane-0 source valid
- src_ready0  out  1  lane-0 accept (combinational from registered state)
- src_data1  in  8  lane-1 source byte
- src_valid1  in  1  lane-1 source valid
- src_ready1  out  1  lane-1 accept
- credit_ret0  in  1  one-cycle pulse, returns one lane-0 credit
- credit_ret1  in  1  one-cycle pulse, returns one lane-1 credit
- data_out0  out  8  byte to PHY lane 0 (registered)
- valid_out0  out  1  lane-0 valid (registered)
- data_out1  out  8  byte to PHY lane 1 (registered)
- valid_out1  out  1  lane-1 valid (registered)
- link_state  out  2  0 RESET, 1 INIT, 2 IDLE, 3 ACTIVE
- link_up  out  1  high iff link_state == ACTIVE

Behaviour:
- Interface: one clock, clk_2f. reset is synchronous and active-high.
- On reset:
  - link_state = RESET.
  - data_out0/1 = 8'h00; valid_out0/1 = 0.
  - credit0/1 = CREDIT_MAX; init counter = 0.
  - src_ready0/1 = 0; link_up = 0.
- FSM transitions (evaluated at each clk_2f edge):
  - RESET -> INIT when enable=1; init counter cleared.
  - INIT -> IDLE after exactly INIT_CYCLES cycles in INIT.
  - IDLE -> ACTIVE after exactly 1 cycle.
  - Any state other than RESET -> RESET when enable=0, taking effect the next cycle. Pending transfers are discarded, credits are restored to CREDIT_MAX, and outputs return to 00/0.
- Output latency is 1 cycle: outputs reflect the state and inputs sampled at the previous edge.
- Per-state outputs:
  - RESET: data 00, valid 0.
  - INIT: data_out0/1 = COM_SYM, valid_out0/1 = 1.
  - IDLE: data_out0/1 = IDL_SYM, valid_out0/1 = 0.
  - ACTIVE: per lane, see the ACTIVE rules below.
- ACTIVE rules, lane N (lanes fully independent unless PHY_LANE_LOCK_EN is defined):
  - src_readyN = (state==ACTIVE) && enable && (creditN != 0).
  - Transfer occurs when src_validN && src_readyN. Next cycle: data_outN = src_dataN, valid_outN = 1, creditN decrements by 1.
  - No transfer: data_outN = IDL_SYM, valid_outN = 0.
- Credit rules:
  - credit_retN increments creditN; it is honoured in every state except RESET.
  - Transfer and return in the same cycle leave creditN unchanged.
  - A return while creditN == CREDIT_MAX is dropped (saturate).
  - creditN never underflows: ready is low at 0.
  - A return at 0 re-raises ready the following cycle.
- Source data is held by the source until accepted. The block never stores more than one byte per lane.

Optional Feature:
- Macro: PHY_LANE_LOCK_EN.
- Defined: lanes advance in lockstep.
  - src_ready0 = src_ready1 = ACTIVE && enable && credit0!=0 && credit1!=0 && src_valid0 && src_valid1.
  - Both lanes transfer together or neither does; both credits decrement together.
  - No combinational loop, since the valids do not depend on ready.
- Undefined: lanes are independent, as in Behaviour.

Decomposition:
- Package phy_tx_pkg holds:
  - link state encodings (RESET/INIT/IDLE/ACTIVE),
  - default COM_SYM/IDL_SYM constants,
  - the 2-bit link_state type.
- Sub-module phy_credit_cnt (inputs: clk_2f, reset, restore, take, give; outputs: count, nonzero):
  - saturating at CREDIT_MAX, floor at 0;
  - instantiated once per lane.

Test Plan:
- Reset then enable=1, INIT_CYCLES=16 -> 16 cycles of BC/BC valid 1/1, then 1 cycle 7C/7C valid 0, then link_up=1, link_state=3.
- ACTIVE, lane0 streams 0x01..0x0A continuously, no returns, CREDIT_MAX=8 -> 0x01..0x08 appear one cycle after acceptance, src_ready0 falls after the 8th, lane0 outputs 7C/valid 0; lane1 unaffected.
- Credit exhausted, then pulse credit_ret0 once -> src_ready0 high next cycle, 0x09 transferred, credit back to 0.
- Transfer coincident with credit_ret0 at credit=3 -> credit stays 3. credit_ret0 at credit=8 -> stays 8.
- enable dropped mid-stream in ACTIVE -> next cycle state 0, valid_out0/1=0, data 00, credits=8. Re-enable -> full INIT sequence repeats.
- PHY_LANE_LOCK_EN defined, src_valid0=1, src_valid1=0 -> both ready 0, no transfer. Raise src_valid1 -> both bytes emitted in the same cycle, both credits decrement.
